// File: rtl/lmsm_reg_sequencer_if.sv
// Request/transfer bus between the decode front end and the LM/SM register sequencer.
// Each transfer is offered with xfer_valid and accepted in any cycle where stall is low.
interface lmsm_reg_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int LIST_W = 8,
  parameter int SEL_W  = 3
);
  logic              start;
  logic [LIST_W-1:0] reg_list;
  logic [ADDR_W-1:0] base_addr;
  logic              stall;
  logic              flush;
  logic              busy;
  logic              xfer_valid;
  logic [SEL_W-1:0]  reg_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic              xfer_last;
  logic              done;

  modport master (
    output start, reg_list, base_addr, stall, flush,
    input  busy, xfer_valid, reg_sel, mem_addr, xfer_last, done
  );

  modport slave (
    input  start, reg_list, base_addr, stall, flush,
    output busy, xfer_valid, reg_sel, mem_addr, xfer_last, done
  );
endinterface

// File: rtl/lmsm_reg_sequencer.sv
// Load/store-multiple sequencer: walks a register list lowest bit first, emitting one
// register select and its memory address per cycle, with all outputs registered.
module lmsm_reg_sequencer #(
  parameter int ADDR_W = 16,
  parameter int LIST_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lmsm_reg_sequencer_if.slave   bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_e;

  state_e            state_q, state_d;
  logic [LIST_W-1:0] pend_q, pend_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [SEL_W-1:0]  count_q, count_d;
  logic              busy_q, busy_d;
  logic              xfer_valid_q, xfer_valid_d;
  logic [SEL_W-1:0]  reg_sel_q, reg_sel_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              xfer_last_q, xfer_last_d;
  logic              done_q, done_d;
  logic [LIST_W-1:0] pend_clr;

  function automatic logic [SEL_W-1:0] lowest_idx(input logic [LIST_W-1:0] l);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (l[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  function automatic logic single_bit(input logic [LIST_W-1:0] l);
    return (l != '0) && ((l & (l - LIST_W'(1))) == '0);
  endfunction

  // pend_q holds every bit not yet consumed, including the one currently presented.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    base_d       = base_q;
    count_d      = count_q;
    busy_d       = busy_q;
    xfer_valid_d = xfer_valid_q;
    reg_sel_d    = reg_sel_q;
    mem_addr_d   = mem_addr_q;
    xfer_last_d  = xfer_last_q;
    done_d       = 1'b0;
    pend_clr     = pend_q;
    pend_clr[reg_sel_q] = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          if (bus.reg_list != '0) begin
            state_d      = RUN;
            pend_d       = bus.reg_list;
            base_d       = bus.base_addr;
            count_d      = '0;
            busy_d       = 1'b1;
            xfer_valid_d = 1'b1;
            reg_sel_d    = lowest_idx(bus.reg_list);
            mem_addr_d   = bus.base_addr;
            xfer_last_d  = single_bit(bus.reg_list);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d      = IDLE;
          pend_d       = '0;
          count_d      = '0;
          busy_d       = 1'b0;
          xfer_valid_d = 1'b0;
          xfer_last_d  = 1'b0;
        end else if (!bus.stall) begin
          pend_d  = pend_clr;
          count_d = count_q + SEL_W'(1);
          if (xfer_last_q) begin
            state_d      = IDLE;
            count_d      = '0;
            busy_d       = 1'b0;
            xfer_valid_d = 1'b0;
            xfer_last_d  = 1'b0;
            done_d       = 1'b1;
          end else begin
            reg_sel_d   = lowest_idx(pend_clr);
            mem_addr_d  = base_q + {{(ADDR_W - SEL_W){1'b0}}, count_d};
            xfer_last_d = single_bit(pend_clr);
          end
        end
      end
      default: begin
        state_d      = IDLE;
        pend_d       = '0;
        busy_d       = 1'b0;
        xfer_valid_d = 1'b0;
        xfer_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      base_q       <= '0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      xfer_valid_q <= 1'b0;
      reg_sel_q    <= '0;
      mem_addr_q   <= '0;
      xfer_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      base_q       <= base_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      xfer_valid_q <= xfer_valid_d;
      reg_sel_q    <= reg_sel_d;
      mem_addr_q   <= mem_addr_d;
      xfer_last_q  <= xfer_last_d;
      done_q       <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.xfer_valid = xfer_valid_q;
  assign bus.reg_sel    = reg_sel_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.xfer_last  = xfer_last_q;
  assign bus.done       = done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_lmsm_reg_sequencer.sv
// Directed bench for lmsm_reg_sequencer: per-cycle vector table plus a stalled
// sequence checked against an expected queue of selects and addresses.
module tb_lmsm_reg_sequencer;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;

  lmsm_reg_sequencer_if #(.ADDR_W(16), .LIST_W(8), .SEL_W(3)) bus ();

  lmsm_reg_sequencer #(.ADDR_W(16), .LIST_W(8), .SEL_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        start;
    logic [7:0]  list;
    logic [15:0] base;
    logic        stall;
    logic        flush;
    logic        busy;
    logic        valid;
    logic [2:0]  sel;
    logic [15:0] addr;
    logic        last;
    logic        done;
  } vec_t;

  vec_t        vec_q[$];
  logic [2:0]  exp_q[$];
  logic [15:0] exp_addr_q[$];

  task automatic add(input logic r, input logic s, input logic [7:0] l, input logic [15:0] b,
                     input logic st, input logic fl, input logic by, input logic v,
                     input logic [2:0] sel, input logic [15:0] a, input logic la, input logic d);
    vec_t t;
    t.rst_n = r; t.start = s; t.list = l; t.base = b; t.stall = st; t.flush = fl;
    t.busy = by; t.valid = v; t.sel = sel; t.addr = a; t.last = la; t.done = d;
    vec_q.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input vec_t t);
    rst_n         = t.rst_n;
    bus.start     = t.start;
    bus.reg_list  = t.list;
    bus.base_addr = t.base;
    bus.stall     = t.stall;
    bus.flush     = t.flush;
  endtask

  task automatic drive_idle();
    rst_n = 1'b1; bus.start = 1'b0; bus.reg_list = 8'h00; bus.base_addr = 16'h0000;
    bus.stall = 1'b0; bus.flush = 1'b0;
  endtask

  initial begin
    int cyc;
    bit got_done;
    checks = 0;
    errors = 0;
    rst_n = 1'b0; bus.start = 1'b0; bus.reg_list = '0; bus.base_addr = '0;
    bus.stall = 1'b0; bus.flush = 1'b0;

    //   rst start list  base      stl fl   busy vld sel addr     last done
    add(0, 0, 8'h00, 16'h0000, 0, 0,   0, 0, 0, 16'h0000, 0, 0); // reset
    add(1, 1, 8'hA5, 16'h0100, 0, 0,   1, 1, 0, 16'h0100, 0, 0); // sparse list
    add(1, 0, 8'h00, 16'h0000, 0, 0,   1, 1, 2, 16'h0101, 0, 0);
    add(1, 0, 8'h00, 16'h0000, 0, 0,   1, 1, 5, 16'h0102, 0, 0);
    add(1, 0, 8'h00, 16'h0000, 0, 0,   1, 1, 7, 16'h0103, 1, 0);
    add(1, 0, 8'h00, 16'h0000, 0, 0,   0, 0, 7, 16'h0103, 0, 1);
    add(1, 0, 8'h00, 16'h0000, 0, 0,   0, 0, 7, 16'h0103, 0, 0);
    add(1, 1, 8'h00, 16'h1234, 0, 0,   0, 0, 7, 16'h0103, 0, 1); // empty list
    add(1, 0, 8'h00, 16'h0000, 0, 0,   0, 0, 7, 16'h0103, 0, 0);
    add(1, 1, 8'hFF, 16'hFFFC, 0, 0,   1, 1, 0, 16'hFFFC, 0, 0); // full list, wrap
    add(1, 0, 8'h00, 16'h0000, 0, 0,   1, 1, 1, 16'hFFFD, 0, 0);
    add(1, 0, 8'h00, 16'h0000, 0, 0,   1, 1, 2, 16'hFFFE, 0, 0);
    add(1, 0, 8'h00, 16'h0000, 0, 0,   1, 1, 3, 16'hFFFF, 0, 0);
    add(1, 0, 8'h00, 16'h0000, 0, 0,   1, 1, 4, 16'h0000, 0, 0);
    add(1, 0, 8'h00, 16'h0000, 0, 0,   1, 1, 5, 16'h0001, 0, 0);
    add(1, 0, 8'h00, 16'h0000, 0, 0,   1, 1, 6, 16'h0002, 0, 0);
    add(1, 0, 8'h00, 16'h0000, 0, 0,   1, 1, 7, 16'h0003, 1, 0);
    add(1, 0, 8'h00, 16'h0000, 0, 0,   0, 0, 7, 16'h0003, 0, 1);
    add(1, 1, 8'h12, 16'h0040, 0, 0,   1, 1, 1, 16'h0040, 0, 0); // stall
    add(1, 0, 8'h00, 16'h0000, 1, 0,   1, 1, 1, 16'h0040, 0, 0);
    add(1, 0, 8'h00, 16'h0000, 1, 0,   1, 1, 1, 16'h0040, 0, 0);
    add(1, 0, 8'h00, 16'h0000, 1, 0,   1, 1, 1, 16'h0040, 0, 0);
    add(1, 1, 8'h01, 16'h9999, 0, 0,   1, 1, 4, 16'h0041, 1, 0); // start while busy ignored
    add(1, 0, 8'h00, 16'h0000, 0, 0,   0, 0, 4, 16'h0041, 0, 1);
    add(1, 1, 8'hF0, 16'h0200, 0, 0,   1, 1, 4, 16'h0200, 0, 0); // start in done cycle
    add(1, 0, 8'h00, 16'h0000, 0, 0,   1, 1, 5, 16'h0201, 0, 0);
    add(1, 0, 8'h00, 16'h0000, 0, 1,   0, 0, 5, 16'h0201, 0, 0); // flush
    add(1, 1, 8'h01, 16'h0300, 0, 0,   1, 1, 0, 16'h0300, 1, 0);
    add(1, 0, 8'h00, 16'h0000, 0, 0,   0, 0, 0, 16'h0300, 0, 1);
    add(1, 1, 8'h03, 16'h0400, 0, 1,   0, 0, 0, 16'h0300, 0, 0); // flush drops start
    add(1, 1, 8'h0C, 16'h0500, 0, 0,   1, 1, 2, 16'h0500, 0, 0);
    add(0, 0, 8'h00, 16'h0000, 0, 0,   0, 0, 0, 16'h0000, 0, 0); // reset mid-sequence
    add(1, 1, 8'h08, 16'h0600, 0, 0,   1, 1, 3, 16'h0600, 1, 0);
    add(1, 0, 8'h00, 16'h0000, 0, 0,   0, 0, 3, 16'h0600, 0, 1);
    add(1, 0, 8'h00, 16'h0000, 0, 0,   0, 0, 3, 16'h0600, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vec_q.size(); i++) begin
      drive(vec_q[i]);
      @(negedge clk);
      check("busy",       i, 32'(bus.busy),       32'(vec_q[i].busy));
      check("xfer_valid", i, 32'(bus.xfer_valid), 32'(vec_q[i].valid));
      check("reg_sel",    i, 32'(bus.reg_sel),    32'(vec_q[i].sel));
      check("mem_addr",   i, 32'(bus.mem_addr),   32'(vec_q[i].addr));
      check("xfer_last",  i, 32'(bus.xfer_last),  32'(vec_q[i].last));
      check("done",       i, 32'(bus.done),       32'(vec_q[i].done));
      check("state",      i, 32'(dbg_state),      vec_q[i].busy ? 32'd1 : 32'd0);
    end

    // scoreboard: A5 at FFFE with random stalls, address wraps mid-sequence
    exp_q      = '{3'd0, 3'd2, 3'd5, 3'd7};
    exp_addr_q = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    drive_idle();
    bus.start = 1'b1; bus.reg_list = 8'hA5; bus.base_addr = 16'hFFFE;
    @(negedge clk);
    drive_idle();
    got_done = 1'b0;
    cyc = 0;
    while (!got_done && cyc < 60) begin
      if (bus.done) begin
        got_done = 1'b1;
      end else if (bus.xfer_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_xfer", cyc, 32'(bus.reg_sel), 32'hFFFF_FFFF);
        end else begin
          check("sb_reg_sel",   cyc, 32'(bus.reg_sel),   32'(exp_q[0]));
          check("sb_mem_addr",  cyc, 32'(bus.mem_addr),  32'(exp_addr_q[0]));
          check("sb_xfer_last", cyc, 32'(bus.xfer_last), (exp_q.size() == 1) ? 32'd1 : 32'd0);
          bus.stall = 1'($urandom_range(0, 1));
          if (!bus.stall) begin
            void'(exp_q.pop_front());
            void'(exp_addr_q.pop_front());
          end
        end
      end else begin
        bus.stall = 1'b0;
      end
      if (!got_done) begin
        @(negedge clk);
        cyc++;
      end
    end
    bus.stall = 1'b0;
    check("sb_done_seen",    cyc, 32'(got_done),     32'd1);
    check("sb_queue_empty",  cyc, 32'(exp_q.size()), 32'd0);
    check("sb_busy_at_done", cyc, 32'(bus.busy),     32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lmsm_reg_sequencer.md
Name: lmsm_reg_sequencer

Overview:
- Sequencer for load-multiple/store-multiple instructions in the pipelined RISC core.
- Takes an 8-bit register list and a base memory address, then emits one register index per cycle, lowest set bit first.
- The index drives the 3-bit select of the register-address 8:1 mux. The matching memory address (base + transfer count) is emitted alongside it.
- Holds the front end via busy while the sequence is in progress.

Parameters:
- ADDR_W, 16, width of base and generated memory address.
- LIST_W, 8, register-list width; fixed at 8 (one bit per architectural register R0..R7).
- SEL_W, 3, register-select width; fixed at clog2(LIST_W).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  input  1  request pulse; qualifies reg_list and base_addr.
- reg_list  input  8  bit i set = transfer register Ri.
- base_addr  input  ADDR_W  address of first transfer.
- stall  input  1  downstream hold; current transfer not consumed.
- flush  input  1  abort the sequence (branch/mispredict squash).
- busy  output  1  sequence in progress; front end must hold.
- xfer_valid  output  1  reg_sel/mem_addr describe a live transfer.
- reg_sel  output  3  register index for the mux select.
- mem_addr  output  ADDR_W  base_addr + transfer ordinal, modulo 2^ADDR_W.
- xfer_last  output  1  current transfer is the final one.
- done  output  1  one-cycle pulse after the final transfer is consumed, or after an empty list.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; pending list=0; count=0. All outputs are 0: busy, xfer_valid, reg_sel, mem_addr, xfer_last, done. Reset overrides all other inputs, including mid-sequence.
- Priority per edge: rst_n > flush > normal operation (start/stall).
- All outputs are registered. Latency is 1 cycle from start accepted to the first xfer_valid.
- IDLE:
  - start=1, flush=0, reg_list!=0: latch reg_list and base_addr; go to RUN.
    - Next cycle: busy=1, xfer_valid=1, reg_sel = lowest set index, mem_addr = base_addr, xfer_last = (popcount==1).
  - start=1, flush=0, reg_list==0: remain IDLE. Next cycle done=1 for one cycle; busy and xfer_valid stay 0.
  - start=0: no change.
- RUN, consume cycle (xfer_valid=1 and stall=0):
  - Clear the emitted bit from the pending list; increment count.
  - If bits remain: next cycle shows the next-lowest index, mem_addr+1, and xfer_last recomputed (one bit remaining → 1).
  - If the consumed transfer had xfer_last=1: next cycle IDLE, busy=0, xfer_valid=0, done=1 (one cycle).
- RUN, stall=1: reg_sel, mem_addr, xfer_last, xfer_valid and busy all held stable; pending list and count unchanged.
- start while busy=1 is ignored; no queueing.
- start in the same cycle done=1 is accepted (block is IDLE).
- flush=1 in RUN: next cycle IDLE, pending cleared, busy=0, xfer_valid=0, done=0. The transfer presented in the flush cycle counts as not consumed.
- flush=1 together with start in IDLE: start is dropped.
- Address arithmetic: mem_addr = base_addr + count (count 0..7, zero-extended), wraps modulo 2^ADDR_W with no error flag.
- Ordering is strictly ascending register index. reg_sel never shows an index whose bit was clear in the list.
- reg_sel and mem_addr hold their last value when xfer_valid=0. Consumers ignore them when xfer_valid=0.
- Maximum sequence: 8 transfers, 8 busy cycles with no stall.

Test Plan:
- Sparse list, no stall: start, reg_list=8'hA5, base=16'h0100 → reg_sel 0,2,5,7 on consecutive cycles; mem_addr 0100,0101,0102,0103; xfer_last only with reg_sel=7; done=1 the following cycle; busy high exactly 4 cycles.
- Empty list: start, reg_list=8'h00 → done=1 one cycle later; busy and xfer_valid never asserted.
- Full list with wrap: reg_list=8'hFF, base=16'hFFFC → reg_sel 0..7; mem_addr FFFC,FFFD,FFFE,FFFF,0000,0001,0002,0003.
- Stall and ignored start: reg_list=8'h12, base=0x0040; stall=1 for 3 cycles on the first transfer → reg_sel=1 and mem_addr=0040 held 3 cycles, then reg_sel=4 at 0041. A second start pulse during busy has no effect. Back-to-back start in the done cycle begins a new sequence.
- Flush: reg_list=8'hF0, flush=1 while reg_sel=5 is presented → next cycle busy=0, xfer_valid=0, no done pulse. A subsequent start with reg_list=8'h01 runs normally (reg_sel=0, xfer_last=1).
- Reset mid-sequence: rst_n=0 for one edge during RUN → all outputs 0 the next cycle, state IDLE. A start issued afterwards behaves as if from power-up.
